// File: rtl/sram_port_arbiter_if.sv
// Client request/grant bus and SRAM-side port bundle shared by sram_port_arbiter and its users.
// Client fields are flattened per port: client i occupies [i*W +: W].
interface sram_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        wr_req;
    logic [NUM_REQ-1:0]        wr_lock;
    logic [NUM_REQ*ADDR_W-1:0] wr_addr;
    logic [NUM_REQ*DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]        wr_gnt;
    logic [NUM_REQ-1:0]        rd_req;
    logic [NUM_REQ*ADDR_W-1:0] rd_addr;
    logic [NUM_REQ-1:0]        rd_gnt;
    logic [NUM_REQ-1:0]        rd_vld;
    logic [DATA_W-1:0]         rd_data;
    logic                      sram_wr_en;
    logic [ADDR_W-1:0]         sram_wr_addr;
    logic [DATA_W-1:0]         sram_din;
    logic                      sram_rd_en;
    logic [ADDR_W-1:0]         sram_rd_addr;
    logic [DATA_W-1:0]         sram_dout;

    modport master (
        output wr_req, wr_lock, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
        input  wr_gnt, rd_gnt, rd_vld, rd_data,
        input  sram_wr_en, sram_wr_addr, sram_din, sram_rd_en, sram_rd_addr
    );

    modport slave (
        input  wr_req, wr_lock, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
        output wr_gnt, rd_gnt, rd_vld, rd_data,
        output sram_wr_en, sram_wr_addr, sram_din, sram_rd_en, sram_rd_addr
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one write port and one read port of the packet-buffer SRAM among NUM_REQ clients,
// with independent round-robin per side, write burst lock and a read-return tag pipeline.
module sram_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sram_port_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [IDX_W:0]   NREQ_V  = (IDX_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] BMAX_V  = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    // MSB flags a winner; the first requester found scanning ptr, ptr+1, ... wins.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        logic [IDX_W:0] k;
        res = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            k   = {1'b0, ptr} + j[IDX_W:0];
            k   = (k >= NREQ_V) ? (k - NREQ_V) : k;
            res = req[k[IDX_W-1:0]] ? {1'b1, k[IDX_W-1:0]} : res;
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        logic [IDX_W:0] n;
        n = {1'b0, idx} + {{IDX_W{1'b0}}, 1'b1};
        n = (n >= NREQ_V) ? '0 : n;
        return n[IDX_W-1:0];
    endfunction

    logic [IDX_W:0]       w_wr_pick;
    logic [IDX_W:0]       w_rd_pick;
    logic                 w_lock_hold;
    logic                 w_wr_win;
    logic [IDX_W-1:0]     w_wr_idx;
    logic [NUM_REQ-1:0]   w_wr_gnt;
    logic                 w_rd_win;
    logic [IDX_W-1:0]     w_rd_idx;
    logic [NUM_REQ-1:0]   w_rd_gnt;
    logic [ADDR_W-1:0]    w_wr_addr_sel;
    logic [DATA_W-1:0]    w_wr_data_sel;
    logic [ADDR_W-1:0]    w_rd_addr_sel;

    logic                 r_sram_wr_en;
    logic [ADDR_W-1:0]    r_sram_wr_addr;
    logic [DATA_W-1:0]    r_sram_din;
    logic [IDX_W-1:0]     r_wr_ptr;
    logic                 r_lock_vld;
    logic [IDX_W-1:0]     r_lock_own;
    logic [CNT_W-1:0]     r_burst_cnt;
    logic                 r_sram_rd_en;
    logic [ADDR_W-1:0]    r_sram_rd_addr;
    logic [IDX_W-1:0]     r_rd_ptr;
    logic [NUM_REQ-1:0]   r_rd_tag;
    logic [NUM_REQ-1:0]   r_rd_vld;
    logic [DATA_W-1:0]    r_rd_hold;

    // Write winner: a live lock owner pre-empts round-robin until its burst budget is spent;
    // once spent, the pointer already sits at owner+1 so the owner naturally ranks last.
    always_comb begin
        w_wr_pick   = rr_pick(bus.wr_req, r_wr_ptr);
        w_lock_hold = r_lock_vld & bus.wr_req[r_lock_own] & bus.wr_lock[r_lock_own]
                      & (r_burst_cnt < BMAX_V);
        if (!i_rst_n) begin
            w_wr_win = 1'b0;
            w_wr_idx = '0;
        end else if (w_lock_hold) begin
            w_wr_win = 1'b1;
            w_wr_idx = r_lock_own;
        end else begin
            w_wr_win = w_wr_pick[IDX_W];
            w_wr_idx = w_wr_pick[IDX_W-1:0];
        end
        w_wr_gnt = '0;
        if (w_wr_win) begin
            w_wr_gnt[w_wr_idx] = 1'b1;
        end else begin
            w_wr_gnt = '0;
        end
    end

    // Read winner: plain round-robin, no lock.
    always_comb begin
        w_rd_pick = rr_pick(bus.rd_req, r_rd_ptr);
        if (!i_rst_n) begin
            w_rd_win = 1'b0;
            w_rd_idx = '0;
        end else begin
            w_rd_win = w_rd_pick[IDX_W];
            w_rd_idx = w_rd_pick[IDX_W-1:0];
        end
        w_rd_gnt = '0;
        if (w_rd_win) begin
            w_rd_gnt[w_rd_idx] = 1'b1;
        end else begin
            w_rd_gnt = '0;
        end
    end

    // One-hot AND-OR select of the granted clients' address and data.
    always_comb begin
        w_wr_addr_sel = '0;
        w_wr_data_sel = '0;
        w_rd_addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_wr_addr_sel |= bus.wr_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{w_wr_gnt[i]}};
            w_wr_data_sel |= bus.wr_data[i*DATA_W +: DATA_W] & {DATA_W{w_wr_gnt[i]}};
            w_rd_addr_sel |= bus.rd_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{w_rd_gnt[i]}};
        end
    end

    // Write issue, write pointer and burst-lock bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sram_wr_en   <= 1'b0;
            r_sram_wr_addr <= '0;
            r_sram_din     <= '0;
            r_wr_ptr       <= '0;
            r_lock_vld     <= 1'b0;
            r_lock_own     <= '0;
            r_burst_cnt    <= '0;
        end else begin
            r_sram_wr_en <= w_wr_win;
            if (w_wr_win) begin
                r_sram_wr_addr <= w_wr_addr_sel;
                r_sram_din     <= w_wr_data_sel;
                r_wr_ptr       <= next_ptr(w_wr_idx);
            end
            if (w_lock_hold) begin
                r_burst_cnt <= r_burst_cnt + CNT_ONE;
            end else if (w_wr_win && bus.wr_lock[w_wr_idx]) begin
                r_lock_vld  <= 1'b1;
                r_lock_own  <= w_wr_idx;
                r_burst_cnt <= CNT_ONE;
            end else begin
                r_lock_vld  <= 1'b0;
                r_burst_cnt <= '0;
            end
        end
    end

    // Read issue plus tag pipeline: the tag rides alongside the SRAM access so the
    // returning word is flagged to its issuer; reset flushes in-flight tags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sram_rd_en   <= 1'b0;
            r_sram_rd_addr <= '0;
            r_rd_ptr       <= '0;
            r_rd_tag       <= '0;
            r_rd_vld       <= '0;
            r_rd_hold      <= '0;
        end else begin
            r_sram_rd_en <= w_rd_win;
            if (w_rd_win) begin
                r_sram_rd_addr <= w_rd_addr_sel;
                r_rd_ptr       <= next_ptr(w_rd_idx);
            end
            r_rd_tag <= w_rd_gnt;
            r_rd_vld <= r_rd_tag;
            if (|r_rd_vld) begin
                r_rd_hold <= bus.sram_dout;
            end
        end
    end

    assign bus.wr_gnt       = w_wr_gnt;
    assign bus.rd_gnt       = w_rd_gnt;
    assign bus.sram_wr_en   = r_sram_wr_en;
    assign bus.sram_wr_addr = r_sram_wr_addr;
    assign bus.sram_din     = r_sram_din;
    assign bus.sram_rd_en   = r_sram_rd_en;
    assign bus.sram_rd_addr = r_sram_rd_addr;
    assign bus.rd_vld       = r_rd_vld;
    // SRAM data is only valid in its return cycle, so the last returned word is held after it.
    assign bus.rd_data      = (|r_rd_vld) ? bus.sram_dout : r_rd_hold;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: behavioural model plus directed scenarios.
module tb_sram_port_arbiter;
    localparam int N = 4, AW = 11, DW = 16, BMAX = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic chk_en = 1'b0;
    int   tests = 0, fails = 0;
    int   n_lock;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) u_if ();
    sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BMAX)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(u_if.slave));

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 2047) return 16'hAAAA;
        return 16'(a * 32'd37) ^ 16'h5A5A;
    endfunction

    // SRAM device: one write and one read per cycle, read returns old data.
    logic [DW-1:0] env_mem  [0:2047];
    bit            env_seen [0:2047];
    always @(posedge clk) begin
        if (u_if.sram_rd_en)
            u_if.sram_dout <= env_seen[u_if.sram_rd_addr] ? env_mem[u_if.sram_rd_addr]
                                                          : init_val(int'(u_if.sram_rd_addr));
        if (u_if.sram_wr_en) begin
            env_mem[u_if.sram_wr_addr]  <= u_if.sram_din;
            env_seen[u_if.sram_wr_addr] <= 1'b1;
        end
    end

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem  [0:2047];
    bit            m_seen [0:2047];
    int m_wptr, m_rptr, m_owner, m_run, m_lg_w, m_lg_r;
    logic          e_wr_en, e_rd_en;
    logic [AW-1:0] e_wr_addr, e_rd_addr;
    logic [DW-1:0] e_din, e_data1, e_rd_data;
    logic [N-1:0]  e_tag1, e_vld;

    function automatic logic [AW-1:0] wa(input int k); return u_if.wr_addr[k*AW +: AW]; endfunction
    function automatic logic [DW-1:0] wd(input int k); return u_if.wr_data[k*DW +: DW]; endfunction
    function automatic logic [AW-1:0] ra(input int k); return u_if.rd_addr[k*AW +: AW]; endfunction
    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        return m_seen[a] ? m_mem[a] : init_val(int'(a));
    endfunction
    function automatic logic [N-1:0] oh(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction
    function automatic int rr(input logic [N-1:0] req, input int ptr);
        for (int j = 0; j < N; j++)
            if (req[(ptr + j) % N]) return (ptr + j) % N;
        return -1;
    endfunction
    function automatic bit lock_hold();
        return (m_owner >= 0) && u_if.wr_req[m_owner] && u_if.wr_lock[m_owner] && (m_run < BMAX);
    endfunction
    function automatic int exp_wr();
        if (!rst_n) return -1;
        if (lock_hold()) return m_owner;
        return rr(u_if.wr_req, m_wptr);
    endfunction
    function automatic int exp_rd();
        if (!rst_n) return -1;
        return rr(u_if.rd_req, m_rptr);
    endfunction

    task automatic model_step();
        int gw, gr;
        bit hold;
        if (!rst_n) begin
            m_wptr = 0; m_rptr = 0; m_owner = -1; m_run = 0; m_lg_w = -1; m_lg_r = -1;
            e_wr_en = 1'b0; e_rd_en = 1'b0; e_wr_addr = '0; e_rd_addr = '0; e_din = '0;
            e_data1 = '0; e_rd_data = '0; e_tag1 = '0; e_vld = '0;
            return;
        end
        hold = lock_hold();
        gw = exp_wr();
        gr = exp_rd();
        // data lands two cycles after its read grant; reads see writes granted in earlier cycles
        e_vld = e_tag1;
        if (e_tag1 != '0) e_rd_data = e_data1;
        e_tag1  = oh(gr);
        e_rd_en = (gr >= 0);
        if (gr >= 0) begin
            e_rd_addr = ra(gr);
            e_data1   = m_rd(e_rd_addr);
            m_rptr    = (gr + 1) % N;
        end
        e_wr_en = (gw >= 0);
        if (gw >= 0) begin
            e_wr_addr = wa(gw);
            e_din     = wd(gw);
            m_mem[e_wr_addr]  = e_din;
            m_seen[e_wr_addr] = 1'b1;
            m_wptr = (gw + 1) % N;
        end
        if (hold) m_run++;
        else if (gw >= 0 && u_if.wr_lock[gw]) begin m_owner = gw; m_run = 1; end
        else begin m_owner = -1; m_run = 0; end
        m_lg_w = gw;
        m_lg_r = gr;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("wr_gnt",       32'(u_if.wr_gnt),       32'(oh(exp_wr())));
            check("rd_gnt",       32'(u_if.rd_gnt),       32'(oh(exp_rd())));
            check("sram_wr_en",   32'(u_if.sram_wr_en),   32'(e_wr_en));
            check("sram_wr_addr", 32'(u_if.sram_wr_addr), 32'(e_wr_addr));
            check("sram_din",     32'(u_if.sram_din),     32'(e_din));
            check("sram_rd_en",   32'(u_if.sram_rd_en),   32'(e_rd_en));
            check("sram_rd_addr", 32'(u_if.sram_rd_addr), 32'(e_rd_addr));
            check("rd_vld",       32'(u_if.rd_vld),       32'(e_vld));
            check("rd_data",      32'(u_if.rd_data),      32'(e_rd_data));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic set_wr(input int i, input logic req, input logic lk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        u_if.wr_req[i] = req;
        u_if.wr_lock[i] = lk;
        u_if.wr_addr[i*AW +: AW] = a;
        u_if.wr_data[i*DW +: DW] = d;
    endtask
    task automatic set_rd(input int i, input logic req, input logic [AW-1:0] a);
        u_if.rd_req[i] = req;
        u_if.rd_addr[i*AW +: AW] = a;
    endtask
    task automatic clear_all();
        u_if.wr_req = '0; u_if.wr_lock = '0; u_if.rd_req = '0;
    endtask

    logic [N-1:0] seq [5];

    initial begin
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        u_if.wr_req = '0; u_if.wr_lock = '0; u_if.wr_addr = '0; u_if.wr_data = '0;
        u_if.rd_req = '0; u_if.rd_addr = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        u_if.wr_req = '1; u_if.rd_req = '1;
        step(); step(); #1;
        check("rst_wr_gnt", 32'(u_if.wr_gnt), 32'h0);
        check("rst_rd_gnt", 32'(u_if.rd_gnt), 32'h0);
        check("rst_wr_en",  32'(u_if.sram_wr_en), 32'h0);

        // plain rotation among four writers
        step();
        rst_n = 1'b1;
        u_if.rd_req = '0;
        for (int i = 0; i < N; i++) set_wr(i, 1'b1, 1'b0, 11'h100 + 11'(i), 16'h1000 + 16'(i));
        #1 check("rr_gnt0", 32'(u_if.wr_gnt), 32'(seq[0]));
        for (int c = 1; c < 5; c++) begin
            step(); #1;
            check("rr_gnt", 32'(u_if.wr_gnt), 32'(seq[c]));
            check("rr_addr", 32'(u_if.sram_wr_addr), 32'h100 + 32'(c - 1));
        end
        check("rr_din", 32'(u_if.sram_din), 32'h1003);
        step(); #1;
        check("rr_addr5", 32'(u_if.sram_wr_addr), 32'h100);
        clear_all();

        // write then read back two cycles later
        step();
        set_wr(2, 1'b1, 1'b0, 11'h055, 16'hBEEF);
        #1 check("wb_wgnt", 32'(u_if.wr_gnt), 32'h4);
        step(); clear_all();
        step(); set_rd(0, 1'b1, 11'h055);
        #1 check("wb_rgnt", 32'(u_if.rd_gnt), 32'h1);
        step(); clear_all();
        #1 check("wb_vld_early", 32'(u_if.rd_vld), 32'h0);
        step(); #1;
        check("wb_vld", 32'(u_if.rd_vld), 32'h1);
        check("wb_data", 32'(u_if.rd_data), 32'hBEEF);

        // locked burst from client 1 against three competitors
        step();
        for (int i = 0; i < N; i++) set_wr(i, 1'b1, (i == 1), 11'h200 + 11'(i), 16'h2000 + 16'(i));
        n_lock = 0;
        for (int k = 0; k < 48; k++) begin
            #1;
            if (u_if.wr_gnt == 4'b0010) n_lock++;
            else if (n_lock > 0) break;
            step();
        end
        check("lock_len", 32'(n_lock), 32'd32);
        check("lock_next", 32'(u_if.wr_gnt), 32'h4);
        step(); #1;
        check("lock_rot", 32'(u_if.wr_gnt), 32'h8);
        clear_all();

        // same-address write and read in one cycle: read sees old data
        step();
        set_wr(0, 1'b1, 1'b0, 11'h7FF, 16'h1234);
        set_rd(3, 1'b1, 11'h7FF);
        #1 check("col_wgnt", 32'(u_if.wr_gnt), 32'h1);
        check("col_rgnt", 32'(u_if.rd_gnt), 32'h8);
        step(); clear_all();
        step(); #1;
        check("col_vld", 32'(u_if.rd_vld), 32'h8);
        check("col_old", 32'(u_if.rd_data), 32'hAAAA);
        set_rd(3, 1'b1, 11'h7FF);
        step(); clear_all();
        step(); #1;
        check("col_new", 32'(u_if.rd_data), 32'h1234);

        // back-to-back reads from clients 0, 2, 3
        set_rd(0, 1'b1, 11'h010); set_rd(2, 1'b1, 11'h020); set_rd(3, 1'b1, 11'h030);
        #1 check("pl_g0", 32'(u_if.rd_gnt), 32'h1);
        step(); u_if.rd_req[0] = 1'b0;
        #1 check("pl_g2", 32'(u_if.rd_gnt), 32'h4);
        step(); u_if.rd_req[2] = 1'b0;
        #1 check("pl_g3", 32'(u_if.rd_gnt), 32'h8);
        check("pl_v0", 32'(u_if.rd_vld), 32'h1);
        check("pl_d0", 32'(u_if.rd_data), 32'h580A);
        step(); clear_all();
        #1 check("pl_v2", 32'(u_if.rd_vld), 32'h4);
        check("pl_d2", 32'(u_if.rd_data), 32'h5EFA);
        step(); #1;
        check("pl_v3", 32'(u_if.rd_vld), 32'h8);
        check("pl_d3", 32'(u_if.rd_data), 32'h5CAA);

        // reset while a read is in flight
        step();
        set_rd(1, 1'b1, 11'h123);
        #1 check("mr_gnt", 32'(u_if.rd_gnt), 32'h2);
        step(); clear_all(); rst_n = 1'b0;
        #1 check("mr_rd_en", 32'(u_if.sram_rd_en), 32'h0);
        step(); #1;
        check("mr_vld", 32'(u_if.rd_vld), 32'h0);
        check("mr_rd_addr", 32'(u_if.sram_rd_addr), 32'h0);
        check("mr_wr_addr", 32'(u_if.sram_wr_addr), 32'h0);
        step(); rst_n = 1'b1;
        u_if.wr_req = '1; u_if.rd_req = '1;
        #1 check("mr_wptr", 32'(u_if.wr_gnt), 32'h1);
        check("mr_rptr", 32'(u_if.rd_gnt), 32'h1);
        step(); clear_all();

        // randomized traffic obeying hold-until-granted
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (u_if.wr_req[i] && m_lg_w == i && u_if.wr_lock[i] && ($urandom_range(0, 15) != 0))
                    set_wr(i, 1'b1, 1'b1, AW'($urandom_range(0, 31)), DW'($urandom));
                else if (!u_if.wr_req[i] || m_lg_w == i)
                    set_wr(i, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                           AW'($urandom_range(0, 31)), DW'($urandom));
                if (!u_if.rd_req[i] || m_lg_r == i)
                    set_rd(i, ($urandom_range(0, 1) == 0), AW'($urandom_range(0, 31)));
            end
        end
        step(); clear_all();
        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-write/single-read 2048x16 packet-buffer SRAM between NUM_REQ client ports.
- Uses independent round-robin arbitration on the write side and the read side.
- Supports burst lock on the write side, so a client can hold the write port for a packet.
- Registers all SRAM-side outputs and routes the 1-cycle SRAM read data back to the client that issued the read, using a tag pipeline.

Parameters:
- NUM_REQ, 4, number of client ports (2..8).
- ADDR_W, 11, SRAM address width.
- DATA_W, 16, SRAM data width.
- BURST_MAX, 32, maximum consecutive write grants one locked client may hold.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_req  in  NUM_REQ  per-client write request.
- wr_lock  in  NUM_REQ  per-client request to keep the write grant on following cycles.
- wr_addr  in  NUM_REQ*ADDR_W  flattened per-client write address; client i occupies bits [i*ADDR_W +: ADDR_W].
- wr_data  in  NUM_REQ*DATA_W  flattened per-client write data.
- wr_gnt  out  NUM_REQ  one-hot write grant (combinational).
- rd_req  in  NUM_REQ  per-client read request.
- rd_addr  in  NUM_REQ*ADDR_W  flattened per-client read address.
- rd_gnt  out  NUM_REQ  one-hot read grant (combinational).
- rd_vld  out  NUM_REQ  one-hot read-data-valid (registered).
- rd_data  out  DATA_W  read data, shared by all clients, qualified by rd_vld.
- sram_wr_en  out  1  SRAM write enable (registered).
- sram_wr_addr  out  ADDR_W  SRAM write address (registered).
- sram_din  out  DATA_W  SRAM write data (registered).
- sram_rd_en  out  1  SRAM read enable (registered).
- sram_rd_addr  out  ADDR_W  SRAM read address (registered).
- sram_dout  in  DATA_W  SRAM read data; valid one cycle after sram_rd_en.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registered outputs go to 0.
  - wr_ptr, rd_ptr and burst counter go to 0; lock owner is cleared.
  - The read tag pipeline is flushed, so in-flight reads never produce rd_vld.
  - wr_gnt and rd_gnt are 0 while reset is asserted.
- Handshake:
  - A client holds req, addr and data stable until it sees gnt high in the same cycle.
  - A transfer occurs on every cycle where req[i] & gnt[i] = 1.
  - At most one bit of wr_gnt and at most one bit of rd_gnt is set per cycle.
  - gnt[i] is never set without req[i].
- Round-robin:
  - Each side has its own pointer (wr_ptr, rd_ptr).
  - The winner is the first requesting client scanning ptr, ptr+1, ... mod NUM_REQ.
  - After a grant to client k, the pointer becomes (k+1) mod NUM_REQ.
  - If nothing is granted, the pointer is unchanged.
- Write burst lock:
  - When the granted client k has wr_lock[k]=1, k becomes lock owner and burst_cnt = 1.
  - While owner k keeps wr_req[k] & wr_lock[k] and burst_cnt < BURST_MAX, k is granted regardless of the pointer, and burst_cnt increments.
  - When the owner drops wr_lock or wr_req, lock is released that cycle and normal round-robin resumes with pointer = owner+1.
  - On reaching burst_cnt = BURST_MAX, the next cycle is forced to normal round-robin with the owner excluded if any other client requests.
  - The forced release then acts as an ordinary release.
  - The read side has no lock.
- Write pipeline:
  - Grant in cycle T drives sram_wr_en=1, sram_wr_addr and sram_din with the winner's values at cycle T+1.
  - With no write grant in T, sram_wr_en=0 in T+1.
- Read pipeline:
  - Grant in cycle T drives sram_rd_en=1 and sram_rd_addr at T+1.
  - The SRAM data returns at T+2, where rd_vld[k]=1 and rd_data = sram_dout.
  - Total read latency is 2 cycles from grant.
  - Back-to-back reads are fully pipelined.
  - rd_data holds its last value when rd_vld=0.
- Simultaneous write and read to the same address in the same SRAM cycle: the read returns the old data. There is no forwarding; clients enforce ordering.
- Throughput: 1 write plus 1 read per cycle, sustained.

Test Plan:
- Reset mid-read: rd_gnt[1] at T, rst_n low at T+1 -> no rd_vld at T+2; all sram_* = 0; pointers = 0.
- All 4 clients hold wr_req, no lock -> wr_gnt sequence 0001, 0010, 0100, 1000, 0001; sram_wr_addr follows the matching addresses one cycle later.
- Client 2 writes addr 0x055 data 0xBEEF, then client 0 reads 0x055 two cycles later -> rd_vld = 0001 with rd_data = 0xBEEF exactly 2 cycles after rd_gnt[0].
- Client 1 locked, all others requesting, BURST_MAX=32 -> 32 consecutive wr_gnt = 0010, then a grant to client 2, then rotation continues.
- Client 3 reads 0x7FF while client 0 writes 0x7FF with 0x1234 (old value 0xAAAA) in the same cycle -> rd_data = 0xAAAA; a subsequent read returns 0x1234.
- Reads from clients 0, 2, 3 on consecutive cycles -> rd_vld = 0001, 0100, 1000 on consecutive cycles with matching data, no bubbles.
